lab4_g61_demux4: RTL
====================

# lab4_g61_demux4

Registered 1-to-4 demultiplexer for 8-bit data with a valid/ready handshake on the input and on each output lane. It is the inverse of the lab's 4:1 selector: one upstream byte stream is distributed either to the lane chosen by `s` (manual mode) or to lanes 0→1→2→3→0 in turn (round-robin mode). Each lane is a one-entry holding register, so a slow consumer stalls only its own lane. A free-running transfer counter supports bench checking.

## Interface
Parameters:
- `WIDTH`, 8, data width of the input and of each lane
- `CNT_W`, 16, width of the accepted-transfer counter

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `din`  in  WIDTH  input byte
- `din_valid`  in  1  `din` is presented this cycle
- `din_ready`  out  1  block accepts `din` this cycle (combinational)
- `s`  in  2  lane select in manual mode
- `auto`  in  1  1 = round-robin mode, 0 = manual mode
- `y0`, `y1`, `y2`, `y3`  out  WIDTH each  lane data registers
- `y_valid`  out  4  bit k = lane k holds undelivered data
- `out_ready`  in  4  bit k = consumer of lane k takes data this cycle
- `cur_sel`  out  2  current target lane (combinational)
- `xfer_cnt`  out  CNT_W  number of accepted input transfers since reset

## Operation
- Target lane `t`: `t = auto ? rr_ptr : s`, with `cur_sel = t`. `rr_ptr` is an internal 2-bit register.
- Lane k can accept when `!y_valid[k] || out_ready[k]`.
- `din_ready` = lane t can accept. It depends only on state, `s`, `auto` and `out_ready`, never on `din_valid`.
- Input transfer: `din_valid && din_ready`. On the next edge `y_t <= din` and `y_valid[t] <= 1`.
- Lane drain: `y_valid[k] && out_ready[k]`. If lane k is not refilled on the same edge, `y_valid[k] <= 0`.
- Drain and fill of the same lane on the same edge: the new byte is loaded, `y_valid[k]` stays 1, and there is no bubble.
- Undrained lanes hold their data. `yk` stays stable while `y_valid[k]=1 && !out_ready[k]`.
- After a drain, `yk` keeps its last value. Lane data registers are not cleared.
- `rr_ptr` advances by 1 (3→0 wrap) only on an accepted transfer with `auto=1`. When `auto=0` it holds its value.
- A mode change takes effect in the same cycle because `t` is combinational. `rr_ptr` is never reloaded from `s`.
- `xfer_cnt` increments on each accepted transfer and wraps modulo 2^CNT_W.
- `out_ready[k]` with `y_valid[k]=0` has no effect.
- Lanes other than t drain independently in the same cycle as the transfer.

## Timing
- Reset values (edge with `rst=1`): `y0..y3 = 0`, `y_valid = 4'b0000`, `rr_ptr = 0`, `xfer_cnt = 0`. After reset `din_ready = 1` and `cur_sel` = `s` or 0 depending on `auto`.
- Reset mid-operation discards all held lane data on that edge. `din_valid` in the reset cycle is ignored and is not counted.
- Latency: data accepted at edge n is visible on `yk` with `y_valid[k]=1` after edge n.
- Throughput: one transfer per cycle whenever the target lane can accept.
- In round-robin mode with all `out_ready` high, four consecutive beats land in lanes 0,1,2,3.
- Stall: with `y_valid[t]=1 && !out_ready[t]`, `din_ready=0` and the upstream must hold `din`. `rr_ptr` does not skip a blocked lane; round-robin is strict.

## Test plan
- Reset then manual fill: `auto=0`, `out_ready=0`, send 0x10,0x11,0x12,0x13 with `s`=0,1,2,3 → `y0..y3` = 0x10..0x13, `y_valid=4'b1111`, `xfer_cnt=4`. A fifth beat with `s=2` sees `din_ready=0` and is not accepted.
- Round-robin with `out_ready=4'b1111`: continuous `din_valid` with 0xA0..0xA7 → lane k receives 0xA0+k and then 0xA4+k. `din_ready` stays 1 throughout. `rr_ptr` wraps 3→0. `xfer_cnt=8`.
- Strict round-robin stall: `auto=1`, `out_ready=4'b1101`, lane 1 already full, `rr_ptr=1` → `din_ready=0`, lanes 0/2/3 untouched. Raise `out_ready[1]` for one cycle → the new byte loads into `y1` with no `y_valid[1]` drop, and `rr_ptr` becomes 2.
- Hold stability: lane 3 holds 0x5A with `out_ready[3]=0` for 10 cycles while other lanes transfer → `y3=0x5A` and `y_valid[3]=1` every cycle. One cycle of `out_ready[3]=1` → `y_valid[3]=0`, `y3` still 0x5A.
- Mode switch: `rr_ptr=2`, switch to `auto=0,s=0`, send 2 beats → both go to lane 0 (after draining) and `rr_ptr` stays 2. Return to `auto=1` → next beat goes to lane 2.
- Reset mid-stream: assert `rr_ptr=3`, `y_valid=4'b1011` and `rst=1` for one cycle with `din_valid=1` → all `y`=0, `y_valid=0`, `xfer_cnt=0`, next auto beat lands in lane 0.

Source files
------------

// File: rtl/lab4_g61_demux4.sv
// Registered 1:4 byte demux (manual select or strict round-robin), one-entry holding register per lane.
// Latency 1 cycle din->lane; din_ready drops only while the target lane is full and its consumer is not ready.
module lab4_g61_demux4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [1:0]       s,
    input  logic             auto,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       cur_sel,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]       y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_q [4];
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [1:0]       tgt;
    logic [3:0]       lane_free;
    logic             xfer;

    assign tgt       = auto ? rr_ptr_q : s;
    assign lane_free = ~y_valid_q | out_ready;
    assign din_ready = lane_free[tgt];
    assign xfer      = din_valid & din_ready;

    // A refill of the target lane overrides its drain, so a full-rate lane never bubbles.
    always_comb begin
        y_valid_d = y_valid_q & ~out_ready;
        if (xfer) begin
            y_valid_d[tgt] = 1'b1;
        end
        rr_ptr_d   = (xfer && auto) ? rr_ptr_q + 2'd1 : rr_ptr_q;
        xfer_cnt_d = xfer ? xfer_cnt_q + CNT_W'(1) : xfer_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            y_valid_q  <= '0;
            xfer_cnt_q <= '0;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            y_valid_q  <= y_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
            if (xfer) begin
                y_q[tgt] <= din;
            end
        end
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y2       = y_q[2];
    assign y3       = y_q[3];
    assign y_valid  = y_valid_q;
    assign cur_sel  = tgt;
    assign xfer_cnt = xfer_cnt_q;

endmodule
